menu_ctrl: RTL and testbench

//  Menu/game sequencer that drives the menu text overlay's 3-bit menu_state select.

---
 rtl/menu_ctrl.sv | 175 +++++++++++++++++
 tb/tb_menu_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/menu_ctrl.sv
// Menu/game sequencer for the text overlay: walks start -> help -> countdown -> race -> result
// and publishes a frame-stable menu_state, countdown digit and blink on vertical-blank edges.
module menu_ctrl #(
  parameter int COUNT_FRAMES = 60,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk_in,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_enter,
  input  logic       key_esc,
  input  logic       race_done,
  output logic [2:0] menu_state,
  output logic [1:0] countdown,
  output logic       blink,
  output logic       race_start,
  output logic       race_active
);

  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_HELP    = 3'd1,
    ST_HELPSCR = 3'd2,
    ST_COUNT   = 3'd3,
    ST_RACE    = 3'd4,
    ST_RESULT  = 3'd5
  } state_t;

  localparam int CW = (COUNT_FRAMES > 1) ? $clog2(COUNT_FRAMES) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(COUNT_FRAMES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   frame_cnt;
  logic [CW-1:0]   frame_nxt;
  logic [1:0]      cnt_digit;
  logic [1:0]      digit_nxt;
  logic [BW-1:0]   blink_cnt;
  logic            vb_d;
  logic            vb_rise;
  logic            nav;

  assign vb_rise = vblnk_in & ~vb_d;
  // up and down pressed together cancel each other
  assign nav     = key_up ^ key_down;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_START;
      frame_cnt <= '0;
      cnt_digit <= 2'd0;
      vb_d      <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= frame_nxt;
      cnt_digit <= digit_nxt;
      vb_d      <= vblnk_in;
    end
  end

  always_comb begin
    state_nxt = state;
    frame_nxt = frame_cnt;
    digit_nxt = cnt_digit;
    case (state)
      ST_START: begin
        if (key_esc) begin
          state_nxt = ST_START;
        end else if (key_enter) begin
          state_nxt = ST_COUNT;
          frame_nxt = '0;
          digit_nxt = 2'd3;
        end else if (nav) begin
          state_nxt = ST_HELP;
        end else begin
          state_nxt = ST_START;
        end
      end
      ST_HELP: begin
        if (key_esc) begin
          state_nxt = ST_HELP;
        end else if (key_enter) begin
          state_nxt = ST_HELPSCR;
        end else if (nav) begin
          state_nxt = ST_START;
        end else begin
          state_nxt = ST_HELP;
        end
      end
      ST_HELPSCR: begin
        if (key_esc || key_enter) begin
          state_nxt = ST_HELP;
        end else begin
          state_nxt = ST_HELPSCR;
        end
      end
      ST_COUNT: begin
        if (key_esc) begin
          state_nxt = ST_START;
        end else if (vb_rise) begin
          if (frame_cnt == COUNT_LAST) begin
            frame_nxt = '0;
            // the last digit hands over to the race instead of reaching zero
            if (cnt_digit == 2'd1) begin
              state_nxt = ST_RACE;
            end else begin
              digit_nxt = cnt_digit - 2'd1;
            end
          end else begin
            frame_nxt = frame_cnt + 1'b1;
          end
        end else begin
          state_nxt = ST_COUNT;
        end
      end
      ST_RACE: begin
        if (key_esc) begin
          state_nxt = ST_START;
        end else if (race_done) begin
          state_nxt = ST_RESULT;
        end else begin
          state_nxt = ST_RACE;
        end
      end
      ST_RESULT: begin
        if (key_esc || key_enter) begin
          state_nxt = ST_START;
        end else begin
          state_nxt = ST_RESULT;
        end
      end
      default: begin
        state_nxt = ST_START;
      end
    endcase
  end

  // Overlay outputs sample the pre-edge state only at the start of vertical blanking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      menu_state  <= 3'd0;
      countdown   <= 2'd0;
      race_start  <= 1'b0;
      race_active <= 1'b0;
    end else if (vb_rise) begin
      menu_state  <= state;
      countdown   <= (state == ST_COUNT) ? cnt_digit : 2'd0;
      race_start  <= (state == ST_RACE) && (menu_state != ST_RACE);
      race_active <= (state == ST_RACE);
    end else begin
      race_start  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (vb_rise) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      blink_cnt <= blink_cnt;
    end
  end

endmodule

// File: tb/tb_menu_ctrl.sv
// Directed bench for menu_ctrl with COUNT_FRAMES=2 and BLINK_FRAMES=2.
module tb_menu_ctrl;

  logic       clk;
  logic       rst;
  logic       vblnk_in;
  logic       key_up;
  logic       key_down;
  logic       key_enter;
  logic       key_esc;
  logic       race_done;
  logic [2:0] menu_state;
  logic [1:0] countdown;
  logic       blink;
  logic       race_start;
  logic       race_active;

  int errors = 0;
  int checks = 0;
  int vb_n   = 0;
  logic [1:0] cd_exp [6];

  menu_ctrl #(.COUNT_FRAMES(2), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .vblnk_in(vblnk_in),
    .key_up(key_up), .key_down(key_down), .key_enter(key_enter), .key_esc(key_esc),
    .race_done(race_done), .menu_state(menu_state), .countdown(countdown),
    .blink(blink), .race_start(race_start), .race_active(race_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic up, input logic down, input logic enter, input logic esc);
    key_up = up; key_down = down; key_enter = enter; key_esc = esc;
    tick();
    key_up = 1'b0; key_down = 1'b0; key_enter = 1'b0; key_esc = 1'b0;
  endtask

  // one-clock vblank pulse; blink model: toggles every second frame since reset
  task automatic vb_pulse();
    vblnk_in = 1'b1;
    tick();
    vb_n++;
    vblnk_in = 1'b0;
    check("blink", {7'd0, blink}, {7'd0, 1'((vb_n / 2) % 2)});
    tick();
  endtask

  task automatic run_countdown();
    press(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      vb_pulse();
      check("cd_digit", {6'd0, countdown}, {6'd0, cd_exp[i]});
      check("cd_state", {5'd0, menu_state}, 8'd3);
    end
    vblnk_in = 1'b1;
    tick();
    vb_n++;
    check("race_state", {5'd0, menu_state}, 8'd4);
    check("race_start_hi", {7'd0, race_start}, 8'd1);
    check("race_active", {7'd0, race_active}, 8'd1);
    check("race_cd_zero", {6'd0, countdown}, 8'd0);
    vblnk_in = 1'b0;
    tick();
    check("race_start_lo", {7'd0, race_start}, 8'd0);
  endtask

  initial begin
    cd_exp = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1};
    rst = 1'b1; vblnk_in = 1'b0; race_done = 1'b0;
    key_up = 1'b0; key_down = 1'b0; key_enter = 1'b0; key_esc = 1'b0;
    tick(); tick();
    check("rst_state", {5'd0, menu_state}, 8'd0);
    check("rst_cd", {6'd0, countdown}, 8'd0);
    check("rst_blink", {7'd0, blink}, 8'd0);
    check("rst_rstart", {7'd0, race_start}, 8'd0);
    check("rst_ractive", {7'd0, race_active}, 8'd0);
    rst = 1'b0;
    tick();

    // keys without vblank do not reach the overlay
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("no_vb_hold", {5'd0, menu_state}, 8'd0);
    vb_pulse();
    check("helpscr", {5'd0, menu_state}, 8'd2);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    vb_pulse();
    check("esc_to_help", {5'd0, menu_state}, 8'd1);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    vb_pulse();
    check("up_to_start", {5'd0, menu_state}, 8'd0);

    // up+down together are ignored
    press(1'b1, 1'b1, 1'b0, 1'b0);
    vb_pulse();
    check("updown_ign", {5'd0, menu_state}, 8'd0);

    // countdown into race, then esc beats race_done
    run_countdown();
    race_done = 1'b1;
    press(1'b0, 1'b0, 1'b0, 1'b1);
    vb_pulse();
    check("esc_over_done", {5'd0, menu_state}, 8'd0);
    check("abort_inactive", {7'd0, race_active}, 8'd0);
    race_done = 1'b0;

    // race finishes normally, result, back to start
    run_countdown();
    race_done = 1'b1;
    tick();
    race_done = 1'b0;
    vb_pulse();
    check("result", {5'd0, menu_state}, 8'd5);
    check("result_inactive", {7'd0, race_active}, 8'd0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    vb_pulse();
    check("result_exit", {5'd0, menu_state}, 8'd0);

    // a long vblank counts as a single frame
    vblnk_in = 1'b1;
    tick();
    vb_n++;
    tick(); tick();
    check("hold_blink_mid", {7'd0, blink}, {7'd0, 1'((vb_n / 2) % 2)});
    repeat (97) tick();
    check("hold_blink_end", {7'd0, blink}, {7'd0, 1'((vb_n / 2) % 2)});
    vblnk_in = 1'b0;
    tick();
    vb_pulse();

    // asynchronous reset mid-countdown
    press(1'b0, 1'b0, 1'b1, 1'b0);
    vb_pulse(); vb_pulse(); vb_pulse();
    check("pre_rst_cd", {6'd0, countdown}, 8'd2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_state", {5'd0, menu_state}, 8'd0);
    check("arst_cd", {6'd0, countdown}, 8'd0);
    check("arst_blink", {7'd0, blink}, 8'd0);
    check("arst_rstart", {7'd0, race_start}, 8'd0);
    check("arst_ractive", {7'd0, race_active}, 8'd0);
    vb_n = 0;
    tick();
    rst = 1'b0;
    tick();
    vb_pulse();
    check("post_rst_state", {5'd0, menu_state}, 8'd0);
    check("post_rst_cd", {6'd0, countdown}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
